// File: rtl/total_alu.sv
// MIPS-style 32-bit execute-stage ALU: combinational R-type ops plus a
// 32-step shift-add unsigned multiplier that writes a HI/LO result pair.
module total_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] Output
);

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] multiplicand;
    logic [63:0] product;
    logic [63:0] product_step;
    logic [32:0] partial;
    logic [4:0]  counter;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        is_multu;

    assign is_multu = (Signal == FN_MULTU);

    // One shift-add step; the 33rd bit keeps the carry so it shifts into bit 63.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        partial = {1'b0, product[63:32]};
        if (product[0]) begin
            partial = partial + {1'b0, multiplicand};
        end
        product_step = {partial, product[31:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_multu) state_next = BUSY;
            BUSY:    if (counter == 5'd31) state_next = DONE;
            DONE:    if (!is_multu) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state        <= IDLE;
            multiplicand <= '0;
            product      <= '0;
            counter      <= '0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_multu) begin
                        multiplicand <= dataA;
                        product      <= {32'b0, dataB};
                        counter      <= '0;
                    end
                end
                BUSY: begin
                    product <= product_step;
                    counter <= counter + 5'd1;
                    if (counter == 5'd31) begin
                        hi <= product_step[63:32];
                        lo <= product_step[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Output = '0;
        case (Signal)
            FN_AND:  Output = dataA & dataB;
            FN_OR:   Output = dataA | dataB;
            FN_ADD:  Output = dataA + dataB;
            FN_SUB:  Output = dataA - dataB;
            FN_SLT:  Output = {31'b0, $signed(dataA) < $signed(dataB)};
            FN_SLL:  Output = dataA << dataB[4:0];
            FN_SRL:  Output = dataA >> dataB[4:0];
            FN_MFHI: Output = hi;
            FN_MFLO: Output = lo;
            default: Output = '0;
        endcase
    end

endmodule

// File: tb/tb_total_alu.sv
// Self-checking bench for total_alu: directed cases, randomized ALU ops and
// randomized multiplies checked against a plain-arithmetic reference model.
module tb_total_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] Output;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    total_alu dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .Output (Output)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: result of one funct code from the instruction-set definition.
    function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        int     sh = int'(b % 32);
        case (fn)
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd32:   return 32'((ua + ub) % 64'h1_0000_0000);
            6'd34:   return 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
            6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
            6'd0:    return 32'((ua * (longint'(1) << sh)) % 64'h1_0000_0000);
            6'd2:    return 32'(ua / (longint'(1) << sh));
            6'd16:   return m_hi;
            6'd18:   return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Apply an op mid-cycle and compare against the model.
    task automatic alu_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b);
        Signal = fn;
        dataA  = a;
        dataB  = b;
        #1;
        check(tag, Output, ref_alu(fn, a, b));
    endtask

    // Read HI then LO without letting a clock edge pass, then restore Signal.
    task automatic read_hilo(input string tag, input logic [5:0] restore);
        Signal = 6'd16;
        #1;
        check({tag, "_hi"}, Output, m_hi);
        Signal = 6'd18;
        #1;
        check({tag, "_lo"}, Output, m_lo);
        Signal = restore;
        #1;
    endtask

    // Start a MULTU and hold it for 35 edges, scrambling operands after the start edge.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        Signal = 6'd25;
        dataA  = a;
        dataB  = b;
        #1;
        check({tag, "_out_zero"}, Output, 32'd0);
        tick(1);
        dataA = $urandom;
        dataB = $urandom;
        tick(34);
        p    = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
        read_hilo(tag, 6'd25);
    endtask

    initial begin
        reset  = 1'b0;
        Signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        tick(1);
        read_hilo("reset", 6'd0);
        reset = 1'b1;
        tick(1);

        alu_op("and", 6'd36, 32'd12, 32'd10);
        check("and_const", Output, 32'd8);
        tick(1);
        alu_op("or", 6'd37, 32'd12, 32'd10);
        check("or_const", Output, 32'd14);
        tick(1);
        alu_op("add", 6'd32, 32'd12, 32'd10);
        check("add_const", Output, 32'd22);
        tick(1);
        alu_op("sub", 6'd34, 32'd12, 32'd10);
        check("sub_const", Output, 32'd2);
        tick(1);
        alu_op("slt", 6'd42, 32'd12, 32'd10);
        check("slt_const", Output, 32'd0);
        tick(1);
        alu_op("sll", 6'd0, 32'd12, 32'd3);
        check("sll_const", Output, 32'd96);
        tick(1);
        alu_op("srl", 6'd2, 32'd12, 32'd2);
        check("srl_const", Output, 32'd3);
        tick(1);
        alu_op("slt_neg", 6'd42, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg_const", Output, 32'd1);
        alu_op("sub_wrap", 6'd34, 32'd0, 32'd1);
        check("sub_wrap_const", Output, 32'd4294967295);
        alu_op("add_wrap", 6'd32, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_const", Output, 32'd0);
        alu_op("unknown63", 6'd63, 32'hDEAD_BEEF, 32'h1234_5678);
        tick(1);

        run_mult("mult1", 32'd100000, 32'd300000);
        check("mult1_hi_const", m_hi, 32'd6);
        check("mult1_lo_const", m_lo, 32'd4230196224);
        // Keep MULTU held well past completion with new operands: no restart.
        dataA = 32'd7;
        dataB = 32'd9;
        tick(40);
        read_hilo("mult1_held", 6'd25);

        Signal = 6'd0;
        tick(1);
        run_mult("mult_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mult_max_hi_const", m_hi, 32'd4294967294);
        check("mult_max_lo_const", m_lo, 32'd1);

        // Back-to-back: one non-MULTU edge, then a new multiply overwrites HI/LO.
        Signal = 6'd0;
        tick(1);
        run_mult("mult_b2b", 32'd123456789, 32'd987654321);

        // Abort at step 10 with reset: HI/LO cleared.
        Signal = 6'd0;
        tick(1);
        Signal = 6'd25;
        dataA  = 32'hCAFE_F00D;
        dataB  = 32'h0BAD_BEEF;
        tick(11);
        reset = 1'b0;
        tick(1);
        reset  = 1'b1;
        Signal = 6'd0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        tick(40);
        read_hilo("mult_abort", 6'd0);

        for (int i = 0; i < 3; i++) begin
            Signal = 6'd0;
            tick(1);
            run_mult($sformatf("mult_rand%0d", i), $urandom, $urandom);
        end
        Signal = 6'd0;
        tick(1);

        for (int i = 0; i < 60; i++) begin
            logic [5:0] fn;
            case ($urandom_range(0, 9))
                0: fn = 6'd36;
                1: fn = 6'd37;
                2: fn = 6'd32;
                3: fn = 6'd34;
                4: fn = 6'd42;
                5: fn = 6'd0;
                6: fn = 6'd2;
                7: fn = 6'd16;
                8: fn = 6'd18;
                default: fn = 6'($urandom_range(0, 63));
            endcase
            if (fn == 6'd25) fn = 6'd63;
            alu_op($sformatf("rand_fn%0d", fn), fn, $urandom, $urandom);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
